// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parametrised register file.
package regfile_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits for decode RAW stalls; a new producer (set)
// outranks a retiring write (clear) on the same register.
module regfile_scoreboard #(
  parameter int NREGS   = 32,
  parameter int AW      = $clog2(NREGS),
  parameter int ZERO_R0 = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_addr,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic          busy_a,
  output logic          busy_b
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bit
    assign w_set[gi] = busy_set && (busy_addr == AW'(gi)) && ((ZERO_R0 == 0) || (gi != 0));
    assign w_clr[gi] = wr_en && (wr_addr == AW'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  // The retiring write is bypassed to the reader, so it must not stall.
  assign busy_a = r_busy[addr_a] & ~(wr_en && (wr_addr == addr_a));
  assign busy_b = r_busy[addr_b] & ~(wr_en && (wr_addr == addr_b));

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write bypass, hardwired zero register,
// post-reset clearing sweep and a busy scoreboard for hazard detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREGS   = NREGS_DEF,
  parameter int AW      = $clog2(NREGS),
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   addr_a,
  input  logic [AW-1:0]   addr_b,
  output logic [XLEN-1:0] data_a,
  output logic [XLEN-1:0] data_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_addr,
  output logic            busy_a,
  output logic            busy_b,
  output logic            init_done
);

  logic [XLEN-1:0] r_mem [NREGS];
  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_next;
  logic            w_run;
  logic            w_wr_en;
  logic            w_busy_set;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic [XLEN-1:0] w_mem_data;
  logic            w_sb_busy_a;
  logic            w_sb_busy_b;
  logic            w_zero_a;
  logic            w_zero_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_run        = 1'b0;
    case (r_state)
      INIT: begin
        w_idx_next = r_idx + 1'b1;
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_next = RUN;
        end
      end
      RUN: w_run = 1'b1;
      default: w_state_next = INIT;
    endcase
  end

  assign w_wr_en    = wr_en && w_run;
  assign w_busy_set = busy_set && w_run;

  // The sweep owns the single write port until the file is usable.
  always_comb begin
    w_mem_we   = 1'b1;
    w_mem_addr = r_idx;
    w_mem_data = '0;
    if (w_run) begin
      w_mem_we   = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));
      w_mem_addr = wr_addr;
      w_mem_data = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  assign w_zero_a = (ZERO_R0 != 0) && (addr_a == '0);
  assign w_zero_b = (ZERO_R0 != 0) && (addr_b == '0);

  assign data_a = (!w_run || w_zero_a) ? '0 :
                  (w_wr_en && (wr_addr == addr_a)) ? wr_data : r_mem[addr_a];
  assign data_b = (!w_run || w_zero_b) ? '0 :
                  (w_wr_en && (wr_addr == addr_b)) ? wr_data : r_mem[addr_b];

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (w_wr_en),
    .wr_addr   (wr_addr),
    .busy_set  (w_busy_set),
    .busy_addr (busy_addr),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .busy_a    (w_sb_busy_a),
    .busy_b    (w_sb_busy_b)
  );

  assign busy_a    = w_sb_busy_a && w_run;
  assign busy_b    = w_sb_busy_b && w_run;
  assign init_done = w_run;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: clearing sweep, bypass, zero register,
// scoreboard priority and mid-run reset.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   addr_a;
  logic [AW-1:0]   addr_b;
  logic [XLEN-1:0] data_a;
  logic [XLEN-1:0] data_b;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            busy_set;
  logic [AW-1:0]   busy_addr;
  logic            busy_a;
  logic            busy_b;
  logic            init_done;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .ZERO_R0 (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .init_done (init_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count the sweep edge by edge; init_done must rise on exactly the NREGS-th.
  task automatic run_sweep(input bit poke_init);
    for (int e = 1; e <= NREGS; e++) begin
      if (poke_init && e >= 10 && e <= 12) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234; addr_a = 5'd5;
        busy_set = 1'b1; busy_addr = 5'd3; addr_b = 5'd3;
        #1;
        chk("init_data_a", data_a, 32'h0);
        chk("init_busy_b", {31'b0, busy_b}, 32'h0);
      end else begin
        wr_en = 1'b0; busy_set = 1'b0;
      end
      tick();
      chk($sformatf("init_done_e%0d", e), {31'b0, init_done}, (e == NREGS) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1; addr_a = '0; addr_b = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; busy_set = 1'b0; busy_addr = '0;
    addr_a = 5'd7; addr_b = 5'd3;
    #1;
    chk("rst_init_done", {31'b0, init_done}, 32'h0);
    chk("rst_data_a", data_a, 32'h0);
    chk("rst_busy_a", {31'b0, busy_a}, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    run_sweep(1'b1);

    for (int a = 0; a < NREGS; a++) begin
      addr_a = AW'(a); addr_b = AW'(NREGS - 1 - a);
      #1;
      chk($sformatf("clear_a_r%0d", a), data_a, 32'h0);
      chk($sformatf("clear_b_r%0d", NREGS - 1 - a), data_b, 32'h0);
    end
    addr_a = 5'd3; #1;
    chk("init_busy_ignored", {31'b0, busy_a}, 32'h0);

    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; addr_a = 5'd7;
    #1;
    chk("bypass_r7", data_a, 32'hDEADBEEF);
    tick();
    wr_en = 1'b0; #1;
    chk("storage_r7", data_a, 32'hDEADBEEF);
    addr_b = 5'd7; #1;
    chk("dual_a_r7", data_a, 32'hDEADBEEF);
    chk("dual_b_r7", data_b, 32'hDEADBEEF);

    addr_a = 5'd0; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    #1;
    chk("r0_bypass", data_a, 32'h0);
    tick();
    wr_en = 1'b0; #1;
    chk("r0_storage", data_a, 32'h0);
    busy_set = 1'b1; busy_addr = 5'd0;
    tick();
    busy_set = 1'b0; #1;
    chk("r0_never_busy", {31'b0, busy_a}, 32'h0);

    busy_set = 1'b1; busy_addr = 5'd3;
    tick();
    busy_set = 1'b0; addr_a = 5'd3; #1;
    chk("busy3_set", {31'b0, busy_a}, 32'h1);
    tick();
    chk("busy3_hold", {31'b0, busy_a}, 32'h1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; #1;
    chk("busy3_masked", {31'b0, busy_a}, 32'h0);
    chk("busy3_bypass", data_a, 32'h55);
    tick();
    wr_en = 1'b0; #1;
    chk("busy3_cleared", {31'b0, busy_a}, 32'h0);
    chk("r3_storage", data_a, 32'h55);

    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    busy_set = 1'b1; busy_addr = 5'd9; addr_a = 5'd9;
    tick();
    wr_en = 1'b0; busy_set = 1'b0; #1;
    chk("busy9_set_wins", {31'b0, busy_a}, 32'h1);
    chk("r9_storage", data_a, 32'h99);

    busy_set = 1'b1; busy_addr = 5'd4;
    tick();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; busy_addr = 5'd6;
    tick();
    wr_en = 1'b0; busy_set = 1'b0; addr_a = 5'd4; addr_b = 5'd6; #1;
    chk("busy4_cleared", {31'b0, busy_a}, 32'h0);
    chk("busy6_set", {31'b0, busy_b}, 32'h1);

    busy_set = 1'b1; busy_addr = 5'd3;
    tick();
    busy_set = 1'b0; addr_a = 5'd7; addr_b = 5'd3; #1;
    chk("pre_rst_busy_b", {31'b0, busy_b}, 32'h1);
    chk("pre_rst_data_a", data_a, 32'hDEADBEEF);
    rst = 1'b1; #1;
    chk("midrst_init_done", {31'b0, init_done}, 32'h0);
    chk("midrst_busy_b", {31'b0, busy_b}, 32'h0);
    chk("midrst_data_a", data_a, 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    run_sweep(1'b0);
    #1;
    chk("resweep_r7", data_a, 32'h0);
    chk("resweep_r3", data_b, 32'h0);
    chk("resweep_busy3", {31'b0, busy_b}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
